// File: rtl/axis_capture_buffer_if.sv
// rtl/axis_capture_buffer_if.sv - sample stream and Wishbone target bundle for axis_capture_buffer
interface axis_capture_buffer_if #(
  parameter int ADR_BITS = 16
);
  logic [127:0]         s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic                 wb_cyc_i;
  logic                 wb_stb_i;
  logic                 wb_we_i;
  logic [ADR_BITS-1:0]  wb_adr_i;
  logic [31:0]          wb_dat_i;
  logic [3:0]           wb_sel_i;
  logic [31:0]          wb_dat_o;
  logic                 wb_ack_o;
  logic                 wb_err_o;
  logic                 wb_rty_o;

  modport master (
    output s_axis_tdata, s_axis_tvalid, wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  s_axis_tready, wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output s_axis_tready, wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/axis_capture_buffer.sv
// rtl/axis_capture_buffer.sv - armed/triggered 128-bit stream capture into RAM with Wishbone readback
// Optional trigger timestamp counter enabled by defining CAPBUF_TIMESTAMP_EN.
module axis_capture_buffer #(
  parameter int DEPTH    = 1024,
  parameter int ADR_BITS = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   capture_i,
  axis_capture_buffer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [127:0]     mem [DEPTH];
  logic [127:0]     rd_beat_q;

  logic             p1_q, p1_we_q, p1_mem_q, p1_ctrl_q, p1_arm_q, p1_abort_q;
  logic [1:0]       p1_lane_q;
  logic [31:0]      p1_reg_q;
  logic             ack_q, ctrl_pend_q, arm_pend_q, abort_pend_q;
  logic [31:0]      dat_q;
  logic [31:0]      tstamp_val;
  logic [31:0]      reg_rd_d;
  logic [31:0]      lane_rd_d;

  logic             busy, accept, is_mem, regs_hit;
  logic [1:0]       reg_idx;
  logic [AW-1:0]    beat_idx;
  logic             ctrl_now, ctrl_arm, ctrl_abort, store, trigger;
  logic [12:0]      count13;

  assign busy     = p1_q | ack_q;
  assign accept   = bus.wb_cyc_i & bus.wb_stb_i & ~busy;
  assign is_mem   = bus.wb_adr_i[ADR_BITS-1];
  assign reg_idx  = bus.wb_adr_i[3:2];
  assign regs_hit = ~|bus.wb_adr_i[ADR_BITS-2:4];
  assign beat_idx = bus.wb_adr_i[4 +: AW];
  assign count13  = 13'(count_q);

  // CTRL pulses act at the edge that closes the ack cycle, and only while cyc is still held.
  assign ctrl_now   = ack_q & bus.wb_cyc_i & ctrl_pend_q;
  assign ctrl_abort = ctrl_now & abort_pend_q;
  assign ctrl_arm   = ctrl_now & arm_pend_q & ~abort_pend_q;

  assign trigger = (state_q == ARMED) & capture_i & ~ctrl_abort;
  assign store   = bus.s_axis_tvalid & ~ctrl_abort &
                   ((state_q == CAPTURE) | ((state_q == ARMED) & capture_i));

  always_comb begin
    reg_rd_d = 32'd0;
    if (regs_hit) begin
      case (reg_idx)
        2'd1:    reg_rd_d = {3'd0, count13, 14'd0, state_q};
        2'd2:    reg_rd_d = tstamp_val;
        default: reg_rd_d = 32'd0;
      endcase
    end
  end

  always_comb begin
    lane_rd_d = rd_beat_q[32*p1_lane_q +: 32];
  end

`ifdef CAPBUF_TIMESTAMP_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] tstamp_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_cnt_q <= 32'd0;
      tstamp_q <= 32'd0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (trigger) tstamp_q <= ts_cnt_q;
    end
  end

  assign tstamp_val = tstamp_q;
`else
  assign tstamp_val = 32'd0;
`endif

  // RAM has no reset so it maps onto a simple dual-port block RAM.
  always_ff @(posedge aclk) begin
    if (store) mem[count_q[AW-1:0]] <= bus.s_axis_tdata;
  end

  always_ff @(posedge aclk) begin
    if (accept) rd_beat_q <= mem[beat_idx];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      count_q <= '0;
    end else if (ctrl_abort) begin
      state_q <= IDLE;
    end else if (ctrl_arm && (state_q == IDLE || state_q == DONE)) begin
      state_q <= ARMED;
      count_q <= '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (capture_i) begin
            state_q <= CAPTURE;
            if (bus.s_axis_tvalid) count_q <= CW'(1);
          end
        end
        CAPTURE: begin
          if (bus.s_axis_tvalid) begin
            count_q <= count_q + CW'(1);
            if (count_q == CW'(DEPTH - 1)) state_q <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      p1_q         <= 1'b0;
      p1_we_q      <= 1'b0;
      p1_mem_q     <= 1'b0;
      p1_ctrl_q    <= 1'b0;
      p1_arm_q     <= 1'b0;
      p1_abort_q   <= 1'b0;
      p1_lane_q    <= 2'd0;
      p1_reg_q     <= 32'd0;
      ack_q        <= 1'b0;
      ctrl_pend_q  <= 1'b0;
      arm_pend_q   <= 1'b0;
      abort_pend_q <= 1'b0;
      dat_q        <= 32'd0;
    end else begin
      p1_q <= accept;
      if (accept) begin
        p1_we_q    <= bus.wb_we_i;
        p1_mem_q   <= is_mem;
        p1_ctrl_q  <= bus.wb_we_i & ~is_mem & regs_hit & (reg_idx == 2'd0) & bus.wb_sel_i[0];
        p1_arm_q   <= bus.wb_dat_i[0];
        p1_abort_q <= bus.wb_dat_i[2];
        p1_lane_q  <= bus.wb_adr_i[3:2];
        p1_reg_q   <= reg_rd_d;
      end
      ack_q        <= p1_q & bus.wb_cyc_i;
      ctrl_pend_q  <= p1_q & bus.wb_cyc_i & p1_ctrl_q;
      arm_pend_q   <= p1_arm_q;
      abort_pend_q <= p1_abort_q;
      if (p1_q && bus.wb_cyc_i && !p1_we_q) dat_q <= p1_mem_q ? lane_rd_d : p1_reg_q;
      else dat_q <= 32'd0;
    end
  end

  assign bus.s_axis_tready = 1'b1;
  assign bus.wb_ack_o      = ack_q;
  assign bus.wb_dat_o      = dat_q;
  assign bus.wb_err_o      = 1'b0;
  assign bus.wb_rty_o      = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{bus.wb_adr_i[1:0], bus.wb_dat_i[31:3], bus.wb_dat_i[1], bus.wb_sel_i[3:1]};

endmodule

// File: tb/tb_axis_capture_buffer.sv
// tb/tb_axis_capture_buffer.sv - scoreboard bench for axis_capture_buffer with DEPTH=16
module tb_axis_capture_buffer;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic capture_i = 1'b0;
  int   cyc_cnt = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
    bit          chk;
    int          id;
  } exp_t;
  exp_t exp_q[$];

  axis_capture_buffer_if #(.ADR_BITS(16)) bus();

  axis_capture_buffer #(.DEPTH(16), .ADR_BITS(16)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .capture_i (capture_i),
    .bus       (bus)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: every ack pops one expectation; latency and read data are checked against it.
  always @(negedge aclk) begin
    total++;
    if (bus.s_axis_tready !== 1'b1) begin
      bad++;
      $display("FAIL tready: got %b want 1", bus.s_axis_tready);
    end
    if (aresetn) begin
      if (bus.wb_ack_o === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack at cycle %0d", cyc_cnt);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cyc_cnt != e.cyc) begin
            bad++;
            $display("FAIL ack_latency id=%0d: ack cycle %0d want %0d", e.id, cyc_cnt, e.cyc);
          end
          if (e.chk) begin
            total++;
            if (bus.wb_dat_o !== e.dat) begin
              bad++;
              $display("FAIL read id=%0d: got %08h want %08h", e.id, bus.wb_dat_o, e.dat);
            end
          end
        end
      end else if (bus.wb_dat_o !== 32'd0) begin
        total++;
        bad++;
        $display("FAIL dat_idle: got %08h want 00000000", bus.wb_dat_o);
      end
    end
  end

  function automatic logic [15:0] mem_adr(input int beat, input int lane);
    return 16'h8000 | 16'(beat << 4) | 16'(lane << 2);
  endfunction

  task automatic wb_xfer(input bit we, input logic [15:0] adr, input logic [31:0] dat,
                         input bit chk, input logic [31:0] expd, input int id);
    exp_t e;
    bit   got;
    @(posedge aclk); #1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = 4'hf;
    e.cyc = cyc_cnt + 2;
    e.dat = expd;
    e.chk = chk;
    e.id  = id;
    exp_q.push_back(e);
    @(posedge aclk); #1;
    bus.wb_stb_i = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge aclk);
      if (bus.wb_ack_o === 1'b1) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_timeout id=%0d: no ack within 8 cycles", id);
      void'(exp_q.pop_back());
    end
    @(posedge aclk); #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic rd(input logic [15:0] adr, input logic [31:0] expd, input int id);
    wb_xfer(1'b0, adr, 32'd0, 1'b1, expd, id);
  endtask

  task automatic wr(input logic [15:0] adr, input logic [31:0] dat, input int id);
    wb_xfer(1'b1, adr, dat, 1'b0, 32'd0, id);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
    end
  endtask

  initial begin
    int rel;
    logic [31:0] v;
    logic [31:0] exp_ts;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    repeat (3) @(posedge aclk);
    #1;
    total++;
    if (bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: ack=%b dat=%08h want 0/0", bus.wb_ack_o, bus.wb_dat_o);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Continuous capture, trigger on beat 3
    rd(16'h0004, 32'h0000_0000, 1);
    wr(16'h0000, 32'h1, 2);
    rd(16'h0004, 32'h0000_0001, 3);
    for (int i = 0; i < 20; i++) begin
      @(posedge aclk); #1;
      v = 32'(i);
      bus.s_axis_tdata  = {4{v}};
      bus.s_axis_tvalid = 1'b1;
      capture_i = (i == 3);
    end
    @(posedge aclk); #1;
    bus.s_axis_tvalid = 1'b0;
    capture_i = 1'b0;
    rd(16'h0004, 32'h0010_0003, 4);
    rd(mem_adr(0, 2), 32'd3, 5);
    rd(mem_adr(15, 0), 32'd18, 6);
    rd(mem_adr(5, 3), 32'd8, 7);
    wr(mem_adr(0, 0), 32'hdead_beef, 8);
    rd(mem_adr(0, 0), 32'd3, 9);
    rd(16'h0000, 32'd0, 10);

    // Alternate-cycle tvalid, trigger on i=4 (valid)
    wr(16'h0000, 32'h1, 11);
    rd(16'h0004, 32'h0000_0001, 12);
    for (int i = 0; i < 40; i++) begin
      @(posedge aclk); #1;
      v = 32'(i);
      bus.s_axis_tdata  = {4{v}};
      bus.s_axis_tvalid = (i % 2 == 0);
      capture_i = (i == 4);
    end
    @(posedge aclk); #1;
    bus.s_axis_tvalid = 1'b0;
    capture_i = 1'b0;
    rd(16'h0004, 32'h0010_0003, 13);
    rd(mem_adr(0, 1), 32'd4, 14);
    rd(mem_adr(7, 3), 32'd18, 15);
    rd(mem_adr(15, 0), 32'd34, 16);

    // capture_i ignored in IDLE, ARM+ABORT, dropped-cyc CTRL write
    wr(16'h0000, 32'h4, 17);
    rd(16'h0004, 32'h0010_0000, 18);
    @(posedge aclk); #1;
    capture_i = 1'b1;
    idle_cycles(3);
    capture_i = 1'b0;
    rd(16'h0004, 32'h0010_0000, 19);
    wr(16'h0000, 32'h1, 20);
    idle_cycles(5);
    rd(16'h0004, 32'h0000_0001, 21);
    @(posedge aclk); #1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 16'h0000;
    bus.wb_dat_i = 32'h4;
    bus.wb_sel_i = 4'hf;
    @(posedge aclk); #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    idle_cycles(4);
    rd(16'h0004, 32'h0000_0001, 22);
    wr(16'h0000, 32'h5, 23);
    rd(16'h0004, 32'h0000_0000, 24);

    // Reset during CAPTURE; RAM keeps contents
    wr(16'h0000, 32'h1, 25);
    for (int i = 0; i < 6; i++) begin
      @(posedge aclk); #1;
      v = 32'(200 + i);
      bus.s_axis_tdata  = {4{v}};
      bus.s_axis_tvalid = 1'b1;
      capture_i = (i == 0);
    end
    aresetn = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    capture_i = 1'b0;
    idle_cycles(2);
    aresetn = 1'b1;
    rel = cyc_cnt;
    rd(16'h0004, 32'h0000_0000, 26);
    rd(mem_adr(2, 0), 32'd202, 27);
    rd(mem_adr(10, 0), 32'd24, 28);

    // Full capture after reset, triggered 1000 cycles after release
    wr(16'h0000, 32'h1, 29);
    do begin
      @(posedge aclk); #1;
    end while (cyc_cnt < rel + 1000);
    for (int k = 0; k < 16; k++) begin
      v = 32'(100 + k);
      bus.s_axis_tdata  = {4{v}};
      bus.s_axis_tvalid = 1'b1;
      capture_i = (k == 0);
      @(posedge aclk); #1;
    end
    bus.s_axis_tvalid = 1'b0;
    capture_i = 1'b0;
    rd(16'h0004, 32'h0010_0003, 30);
    rd(mem_adr(0, 3), 32'd100, 31);
    rd(mem_adr(15, 1), 32'd115, 32);
`ifdef CAPBUF_TIMESTAMP_EN
    exp_ts = 32'd1000;
`else
    exp_ts = 32'd0;
`endif
    rd(16'h0008, exp_ts, 33);

    idle_cycles(4);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
